tick_period_meter: RTL and testbench
====================================

Name: tick_period_meter

Overview:
Measures the period, in clk cycles, of a periodic single-bit tick stream, such as the output of the team's clock-divider block. It is the receiving end of that interface: the divider turns a count into ticks, and this block recovers the count from the ticks. It reports each measured period, flags when the period has been stable for a configurable number of intervals, and flags timeout when no tick arrives within the counter range. Used for divider self-check and for rate monitoring in the CPU test harness.

Parameters:
WIDTH, 32, width of the period counter and of period_out.
LOCK_COUNT, 4, number of consecutive identical periods required to assert locked (legal range 2..255).

Ports:
clk  input  1  clock.
rst  input  1  reset, synchronous, active-high.
en  input  1  measurement enable; low aborts and idles the block.
clear  input  1  one-cycle pulse that clears the sticky overflow flag.
tick_in  input  1  tick stream, synchronous to clk; each rising edge marks the start of a period.
period_out  output  WIDTH  last completed period in clk cycles; held between updates.
period_valid  output  1  one-cycle pulse; period_out was updated this cycle.
locked  output  1  last LOCK_COUNT periods were identical.
overflow  output  1  sticky flag; counter saturated with no tick.

Behaviour:
- Reset values:
  - period_out=0, period_valid=0, locked=0, overflow=0.
  - State=IDLE, counter=0, match count=0, tick_q=0.
- Edge detect:
  - tick_q is tick_in registered.
  - edge = tick_in & ~tick_q, evaluated at each posedge.
  - tick_q updates every cycle, including when en=0.
- Period definition:
  - Edges sampled at posedges k0 and k1 give period = k1-k0.
  - Minimum measurable period is 2 (tick pattern 1,0,1,0).
  - tick_in held high produces no further edges.
- State IDLE:
  - Counter is held at 0.
  - On edge with en=1: counter<=1, go to MEASURE. No period_valid.
- State MEASURE, each cycle with en=1:
  - No edge, counter < 2^WIDTH-1: counter<=counter+1.
  - No edge, counter == 2^WIDTH-1: overflow<=1, locked<=0, match<=0, go to TIMEOUT.
  - Edge: period_out<=counter, period_valid<=1 (visible the cycle after the edge posedge), counter<=1.
- Lock logic, applied on the same edge:
  - If counter == previous period_out and match != 0: match<=min(match+1, LOCK_COUNT).
  - Otherwise: match<=1.
  - locked is registered; it equals (new match == LOCK_COUNT) and updates in the same cycle as period_valid.
  - The first period after IDLE or TIMEOUT always sets match=1.
- State TIMEOUT:
  - Counter is held.
  - On edge: counter<=1, go to MEASURE. No period_valid; period_out keeps its old value.
- en=0, any state: next state IDLE, counter<=0, match<=0, locked<=0. period_out and overflow are held, period_valid=0.
- overflow and clear:
  - overflow is cleared only by rst or clear.
  - If clear and an overflow set happen in the same cycle, the set wins.
- rst mid-measurement: all state returns to reset values on that edge. The next edge after rst is treated as the first edge.
- Counter arithmetic is unsigned WIDTH-bit. It saturates and never wraps.
- period_valid never asserts on two consecutive cycles.

Test Plan:
1. WIDTH=32, LOCK_COUNT=4, en=1, one-cycle tick every 5 clks (edges 1–5) -> period_valid pulses after edges 2,3,4,5, each with period_out=5; locked=0 until the pulse after edge 5, then locked=1.
2. Locked at period 5, then next interval 7 clks -> period_out=7, locked=0 in the same cycle as period_valid; three further 7-clk intervals -> locked=1 on the fourth 7.
3. WIDTH=8, one edge then tick_in=0 for 260 clks -> overflow=1 once counter hits 255, locked=0, no period_valid. A following edge pair 3 clks apart -> period_out=3, overflow stays 1. A clear pulse -> overflow=0.
4. Ticks every 4 clks, en dropped for 2 cycles mid-interval then restored -> locked=0, no period_valid for the interrupted interval, first valid after re-enable occurs at the second edge.
5. rst asserted mid-interval while locked (period 6) -> next cycle all outputs 0. After rst, the first period_valid appears at the second edge with period_out=6.
6. tick_in toggling every cycle -> period_out=2, period_valid one-cycle pulses every 2 clks, locked=1 after 4 equal periods. tick_in stuck high -> no further valid pulses.

Source files
------------

// File: rtl/tick_period_meter.sv
`default_nettype none
// ============================================================================
// Module   : tick_period_meter
// Purpose  : Measures the clk-cycle period of a tick stream, reports it,
//            flags lock on repeated equal periods and sticky timeout.
// Revision : 1.0  initial release
// ============================================================================
module tick_period_meter #(
    parameter int WIDTH      = 32,
    parameter int LOCK_COUNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clear,
    input  logic             tick_in,
    output logic [WIDTH-1:0] period_out,
    output logic             period_valid,
    output logic             locked,
    output logic             overflow
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MEASURE = 2'd1,
        S_TIMEOUT = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] C_CNT_MAX = '1;
    localparam logic [WIDTH-1:0] C_CNT_ONE = WIDTH'(1);
    localparam logic [7:0]       C_LOCK    = 8'(LOCK_COUNT);

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [7:0]       r_match;
    logic             r_tick_q;

    logic             w_edge;
    logic             w_same;
    logic [7:0]       w_match_next;

    assign w_edge = tick_in & ~r_tick_q;

    // A zero match count marks the first period after IDLE/TIMEOUT, which
    // must never be compared against a stale period_out.
    assign w_same       = (r_count == period_out) && (r_match != 8'd0);
    assign w_match_next = !w_same              ? 8'd1 :
                          (r_match >= C_LOCK)  ? C_LOCK :
                                                 r_match + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_count      <= '0;
            r_match      <= 8'd0;
            r_tick_q     <= 1'b0;
            period_out   <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            r_tick_q     <= tick_in;
            period_valid <= 1'b0;
            if (clear) begin
                overflow <= 1'b0;
            end
            if (!en) begin
                r_state <= S_IDLE;
                r_count <= '0;
                r_match <= 8'd0;
                locked  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_edge) begin
                            r_count <= C_CNT_ONE;
                            r_state <= S_MEASURE;
                        end else begin
                            r_count <= '0;
                        end
                    end
                    S_MEASURE: begin
                        if (w_edge) begin
                            period_out   <= r_count;
                            period_valid <= 1'b1;
                            r_count      <= C_CNT_ONE;
                            r_match      <= w_match_next;
                            locked       <= (w_match_next == C_LOCK);
                        end else if (r_count == C_CNT_MAX) begin
                            // Set is placed after the clear so it wins a collision.
                            overflow <= 1'b1;
                            locked   <= 1'b0;
                            r_match  <= 8'd0;
                            r_state  <= S_TIMEOUT;
                        end else begin
                            r_count <= r_count + C_CNT_ONE;
                        end
                    end
                    S_TIMEOUT: begin
                        if (w_edge) begin
                            r_count <= C_CNT_ONE;
                            r_state <= S_MEASURE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_count <= '0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tick_period_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tick_period_meter
// Purpose  : Self-checking bench for tick_period_meter (edge-timestamp model).
// Revision : 1.0  initial release
// ============================================================================
module tb_tick_period_meter;

    localparam int W    = 8;
    localparam int LC   = 4;
    localparam int MAXC = 255;

    logic         clk = 1'b0;
    logic         rst, en, clear, tick_in;
    logic [W-1:0] period_out;
    logic         period_valid, locked, overflow;

    always #5 clk = ~clk;

    tick_period_meter #(.WIDTH(W), .LOCK_COUNT(LC)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .clear        (clear),
        .tick_in      (tick_in),
        .period_out   (period_out),
        .period_valid (period_valid),
        .locked       (locked),
        .overflow     (overflow)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: timestamps of rising edges and a history of periods.
    int  cyc = 0;
    bit  m_prev, m_have, m_valid, m_ovf, m_locked;
    int  m_ref, m_period;
    int  hist[$];

    int  vcnt, vlast;

    typedef struct {
        int period;
        int reps;
        int exp_period;
        bit exp_locked;
        int exp_valids;
    } row_t;
    row_t rows[5];

    function automatic bit lock_of();
        if (hist.size() < LC) return 1'b0;
        foreach (hist[i]) if (hist[i] != hist[0]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        bit e, set;
        @(posedge clk);
        if (rst) begin
            m_prev = 0; m_have = 0; m_period = 0; m_valid = 0; m_ovf = 0;
            hist.delete();
        end else begin
            e = tick_in && !m_prev;
            set = 0;
            m_valid = 0;
            if (!en) begin
                m_have = 0;
                hist.delete();
            end else if (e) begin
                if (m_have) begin
                    m_period = cyc - m_ref;
                    m_valid  = 1;
                    hist.push_back(m_period);
                    if (hist.size() > LC) void'(hist.pop_front());
                end
                m_have = 1;
                m_ref  = cyc;
            end else if (m_have && (cyc - m_ref) == MAXC) begin
                set    = 1;
                m_have = 0;
                hist.delete();
            end
            if (clear) m_ovf = 0;
            if (set)   m_ovf = 1;
            m_prev = tick_in;
        end
        m_locked = lock_of();
        cyc++;
        #1;
        checks++;
        if (int'(period_out) != m_period || period_valid !== m_valid ||
            locked !== m_locked || overflow !== m_ovf) begin
            failures++;
            $display("FAIL model cyc=%0d: got p=%0d v=%b l=%b o=%b expected p=%0d v=%b l=%b o=%b",
                     cyc, period_out, period_valid, locked, overflow,
                     m_period, m_valid, m_locked, m_ovf);
        end
        if (period_valid) begin
            vcnt++;
            vlast = int'(period_out);
        end
    endtask

    // Edge placed p cycles after the previous one.
    task automatic gap_edge(input int p);
        tick_in = 1'b0;
        repeat (p - 1) step();
        tick_in = 1'b1;
        step();
    endtask

    initial begin
        int mode, p, n;
        rst = 1'b1; en = 1'b0; clear = 1'b0; tick_in = 1'b0;
        vcnt = 0; vlast = 0;
        step(); step();
        chk("reset_period", int'(period_out), 0);
        chk("reset_valid", int'(period_valid), 0);
        chk("reset_locked", int'(locked), 0);
        chk("reset_overflow", int'(overflow), 0);

        rst = 1'b0; en = 1'b1;

        rows[0] = '{period: 5, reps: 5, exp_period: 5, exp_locked: 1'b1, exp_valids: 4};
        rows[1] = '{period: 7, reps: 1, exp_period: 7, exp_locked: 1'b0, exp_valids: 1};
        rows[2] = '{period: 7, reps: 3, exp_period: 7, exp_locked: 1'b1, exp_valids: 3};
        rows[3] = '{period: 2, reps: 4, exp_period: 2, exp_locked: 1'b1, exp_valids: 4};
        rows[4] = '{period: 3, reps: 2, exp_period: 3, exp_locked: 1'b0, exp_valids: 2};
        foreach (rows[r]) begin
            vcnt = 0;
            repeat (rows[r].reps) gap_edge(rows[r].period);
            chk($sformatf("row%0d_valids", r), vcnt, rows[r].exp_valids);
            chk($sformatf("row%0d_period", r), vlast, rows[r].exp_period);
            chk($sformatf("row%0d_locked", r), int'(locked), int'(rows[r].exp_locked));
        end

        // tick stuck high: no further edges
        tick_in = 1'b1; vcnt = 0;
        repeat (20) step();
        chk("stuck_high_valids", vcnt, 0);

        // timeout and sticky overflow
        gap_edge(3);
        tick_in = 1'b0; vcnt = 0;
        repeat (260) step();
        chk("timeout_overflow", int'(overflow), 1);
        chk("timeout_locked", int'(locked), 0);
        chk("timeout_valids", vcnt, 0);
        vcnt = 0;
        gap_edge(3); gap_edge(3);
        chk("after_timeout_valids", vcnt, 1);
        chk("after_timeout_period", int'(period_out), 3);
        chk("overflow_sticky", int'(overflow), 1);
        clear = 1'b1; step(); clear = 1'b0;
        chk("overflow_cleared", int'(overflow), 0);

        // clear colliding with the saturating cycle: set wins
        gap_edge(2);
        tick_in = 1'b0;
        repeat (254) step();
        clear = 1'b1; step(); clear = 1'b0;
        chk("set_beats_clear", int'(overflow), 1);

        // enable dropped mid-interval
        repeat (5) gap_edge(4);
        chk("pre_drop_locked", int'(locked), 1);
        tick_in = 1'b0; step();
        en = 1'b0; repeat (2) step();
        chk("drop_locked", int'(locked), 0);
        en = 1'b1; vcnt = 0;
        tick_in = 1'b1; step();
        chk("reenable_first_edge", vcnt, 0);
        gap_edge(4);
        chk("reenable_second_valid", vcnt, 1);
        chk("reenable_period", vlast, 4);
        chk("reenable_locked", int'(locked), 0);

        // reset mid-interval while locked
        repeat (5) gap_edge(6);
        chk("pre_rst_locked", int'(locked), 1);
        tick_in = 1'b0; repeat (2) step();
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_outputs", {int'(period_out), int'(period_valid), int'(locked), int'(overflow)} == 0 ? 0 : 1, 0);
        vcnt = 0;
        gap_edge(6);
        chk("post_rst_first_edge", vcnt, 0);
        gap_edge(6);
        chk("post_rst_valids", vcnt, 1);
        chk("post_rst_period", vlast, 6);

        // randomized traffic against the model
        for (int b = 0; b < 60; b++) begin
            mode = $urandom_range(0, 3);
            rst = 1'b0; en = 1'b1; clear = 1'b0;
            case (mode)
                0: begin
                    n = $urandom_range(10, 40);
                    repeat (n) begin
                        tick_in = ($urandom % 3 == 0);
                        en      = ($urandom % 20 != 0);
                        clear   = ($urandom % 25 == 0);
                        rst     = ($urandom % 200 == 0);
                        step();
                    end
                end
                1: begin
                    p = $urandom_range(2, 9);
                    n = $urandom_range(3, 8);
                    repeat (n) gap_edge(p);
                end
                2: begin
                    tick_in = 1'b0;
                    n = $urandom_range(250, 262);
                    repeat (n) step();
                end
                default: begin
                    tick_in = 1'b1;
                    n = $urandom_range(1, 6);
                    repeat (n) step();
                end
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
